// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sseg_pkg
// Purpose  : Glyph constants and the position-to-(digit, glyph) mapping used
//            by the rotating-square animator.
// Revision : 1.0
// ============================================================================
package sseg_pkg;

    localparam logic [6:0] SEG_TOP   = 7'b0011100;
    localparam logic [6:0] SEG_BOT   = 7'b0100011;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic [2:0] digit;
        logic [6:0] glyph;
    } pos_map_t;

    // Top row runs leftmost->rightmost, bottom row returns rightmost->leftmost.
    function automatic pos_map_t pos_map(input logic [3:0] p, input int unsigned n);
        pos_map_t m;
        if (32'(p) < n) begin
            m.digit = 3'(n - 32'd1 - 32'(p));
            m.glyph = SEG_TOP;
        end else begin
            m.digit = 3'(32'(p) - n);
            m.glyph = SEG_BOT;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rotating_square_disp_if.sv
`default_nettype none
// ============================================================================
// Module   : rotating_square_disp_if
// Purpose  : Control inputs and display outputs of the rotating-square block.
// Revision : 1.0
// ============================================================================
interface rotating_square_disp_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int POS_W = $clog2(2 * NUM_DIGITS);

    logic                  en;
    logic                  cw;
    logic [6:0]            sseg;
    logic [NUM_DIGITS-1:0] an;
    logic [POS_W-1:0]      pos;
    logic                  step;

    modport master (output en, cw, input sseg, an, pos, step);
    modport slave  (input en, cw, output sseg, an, pos, step);

endinterface
`default_nettype wire

// File: rtl/mod_m_tick.sv
`default_nettype none
// ============================================================================
// Module   : mod_m_tick
// Purpose  : Enabled modulo-M counter with a terminal-count strobe.
// Revision : 1.0
// ============================================================================
module mod_m_tick #(
    parameter int M   = 4,
    parameter int C_W = (M > 1) ? $clog2(M) : 1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_en,
    output logic      o_tc
);
    localparam logic [C_W-1:0] c_LAST = C_W'(M - 1);

    logic [C_W-1:0] r_cnt;
    logic           w_tc;

    // Strobe only while enabled so a frozen count never fires.
    assign w_tc = i_en && (r_cnt == c_LAST);
    assign o_tc = w_tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rotating_square_disp.sv
`default_nettype none
// ============================================================================
// Module   : rotating_square_disp
// Purpose  : Square glyph circling an N-digit seven-segment display, with
//            programmable step rate, run/pause, direction and a scan driver.
// Revision : 1.0
// ============================================================================
module rotating_square_disp
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50_000_000,
    parameter int SCAN_DIV   = 100_000
) (
    input  wire logic             clk,
    input  wire logic             reset,
    rotating_square_disp_if.slave bus
);
    localparam int                    c_POS_W   = $clog2(2 * NUM_DIGITS);
    localparam logic [c_POS_W-1:0]    c_POS_MAX = c_POS_W'(2 * NUM_DIGITS - 1);
    localparam logic [2:0]            c_IDX_MAX = 3'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_ONE     = NUM_DIGITS'(1);

    logic                  w_step_evt;
    logic                  w_scan_wrap;
    pos_map_t              w_map;

    logic [c_POS_W-1:0]    r_pos;
    logic                  r_step;
    logic [2:0]            r_scan_idx;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_sseg;

    mod_m_tick #(.M(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (reset),
        .i_en (bus.en),
        .o_tc (w_step_evt)
    );

    mod_m_tick #(.M(SCAN_DIV)) u_scan (
        .clk  (clk),
        .rst  (reset),
        .i_en (1'b1),
        .o_tc (w_scan_wrap)
    );

    assign w_map = pos_map(4'(r_pos), NUM_DIGITS);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos      <= '0;
            r_step     <= 1'b0;
            r_scan_idx <= '0;
            r_an       <= '1;
            r_sseg     <= SEG_BLANK;
        end else begin
            r_step <= w_step_evt;
            // Explicit wrap: 2N is not always a power of two.
            if (w_step_evt) begin
                if (bus.cw) begin
                    r_pos <= (r_pos == c_POS_MAX) ? '0 : r_pos + 1'b1;
                end else begin
                    r_pos <= (r_pos == '0) ? c_POS_MAX : r_pos - 1'b1;
                end
            end
            if (w_scan_wrap) begin
                r_scan_idx <= (r_scan_idx == c_IDX_MAX) ? '0 : r_scan_idx + 1'b1;
            end
            r_an   <= ~(c_ONE << r_scan_idx);
            r_sseg <= (r_scan_idx == w_map.digit) ? w_map.glyph : SEG_BLANK;
        end
    end

    assign bus.pos  = r_pos;
    assign bus.step = r_step;
    assign bus.an   = r_an;
    assign bus.sseg = r_sseg;

endmodule
`default_nettype wire

// File: tb/tb_rotating_square_disp.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotating_square_disp
// Purpose  : Directed vector bench for rotating_square_disp (N=4, TICK=4,
//            SCAN=2).
// Revision : 1.0
// ============================================================================
module tb_rotating_square_disp;

    localparam logic [6:0] T = 7'b0011100;
    localparam logic [6:0] B = 7'b0100011;
    localparam logic [6:0] K = 7'b1111111;

    typedef struct {
        logic       rst;
        logic       en;
        logic       cw;
        logic [3:0] an;
        logic [6:0] sseg;
        logic [2:0] pos;
        logic       step;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vt[29];

    always #5 clk = ~clk;

    rotating_square_disp_if #(.NUM_DIGITS(4)) bus ();

    rotating_square_disp #(
        .NUM_DIGITS (4),
        .TICK_DIV   (4),
        .SCAN_DIV   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic vec_t mk(input logic r, input logic e, input logic c,
                                input logic [3:0] a, input logic [6:0] s,
                                input logic [2:0] p, input logic st);
        vec_t v;
        v.rst = r; v.en = e; v.cw = c; v.an = a; v.sseg = s; v.pos = p; v.step = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic e, input logic c);
        reset  = r;
        bus.en = e;
        bus.cw = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, then en=0 until digit 3 is scanned, then run clockwise.
        vt[0]  = mk(1'b1, 1'b0, 1'b1, 4'b1111, K, 3'd0, 1'b0);
        vt[1]  = mk(1'b1, 1'b0, 1'b1, 4'b1111, K, 3'd0, 1'b0);
        vt[2]  = mk(1'b1, 1'b0, 1'b1, 4'b1111, K, 3'd0, 1'b0);
        vt[3]  = mk(1'b0, 1'b0, 1'b1, 4'b1110, K, 3'd0, 1'b0);
        vt[4]  = mk(1'b0, 1'b0, 1'b1, 4'b1110, K, 3'd0, 1'b0);
        vt[5]  = mk(1'b0, 1'b0, 1'b1, 4'b1101, K, 3'd0, 1'b0);
        vt[6]  = mk(1'b0, 1'b0, 1'b1, 4'b1101, K, 3'd0, 1'b0);
        vt[7]  = mk(1'b0, 1'b0, 1'b1, 4'b1011, K, 3'd0, 1'b0);
        vt[8]  = mk(1'b0, 1'b0, 1'b1, 4'b1011, K, 3'd0, 1'b0);
        vt[9]  = mk(1'b0, 1'b0, 1'b1, 4'b0111, T, 3'd0, 1'b0);
        vt[10] = mk(1'b0, 1'b1, 1'b1, 4'b0111, T, 3'd0, 1'b0);
        vt[11] = mk(1'b0, 1'b1, 1'b1, 4'b1110, K, 3'd0, 1'b0);
        vt[12] = mk(1'b0, 1'b1, 1'b1, 4'b1110, K, 3'd0, 1'b0);
        vt[13] = mk(1'b0, 1'b1, 1'b1, 4'b1101, K, 3'd1, 1'b1);
        vt[14] = mk(1'b0, 1'b1, 1'b1, 4'b1101, K, 3'd1, 1'b0);
        vt[15] = mk(1'b0, 1'b1, 1'b1, 4'b1011, T, 3'd1, 1'b0);
        vt[16] = mk(1'b0, 1'b1, 1'b1, 4'b1011, T, 3'd1, 1'b0);
        vt[17] = mk(1'b0, 1'b1, 1'b1, 4'b0111, K, 3'd2, 1'b1);
        vt[18] = mk(1'b0, 1'b1, 1'b1, 4'b0111, K, 3'd2, 1'b0);
        vt[19] = mk(1'b0, 1'b1, 1'b1, 4'b1110, K, 3'd2, 1'b0);
        vt[20] = mk(1'b0, 1'b1, 1'b1, 4'b1110, K, 3'd2, 1'b0);
        vt[21] = mk(1'b0, 1'b1, 1'b1, 4'b1101, T, 3'd3, 1'b1);
        vt[22] = mk(1'b0, 1'b1, 1'b1, 4'b1101, K, 3'd3, 1'b0);
        vt[23] = mk(1'b0, 1'b1, 1'b1, 4'b1011, K, 3'd3, 1'b0);
        vt[24] = mk(1'b0, 1'b1, 1'b1, 4'b1011, K, 3'd3, 1'b0);
        vt[25] = mk(1'b0, 1'b1, 1'b1, 4'b0111, K, 3'd4, 1'b1);
        vt[26] = mk(1'b0, 1'b1, 1'b1, 4'b0111, K, 3'd4, 1'b0);
        vt[27] = mk(1'b0, 1'b1, 1'b1, 4'b1110, B, 3'd4, 1'b0);
        vt[28] = mk(1'b0, 1'b1, 1'b1, 4'b1110, B, 3'd4, 1'b0);

        for (int i = 0; i < 29; i++) begin
            tick(vt[i].rst, vt[i].en, vt[i].cw);
            chk($sformatf("vec%0d {an,sseg,pos,step}", i),
                32'({bus.an, bus.sseg, bus.pos, bus.step}),
                32'({vt[i].an, vt[i].sseg, vt[i].pos, vt[i].step}));
        end

        // Continue clockwise through the 7->0 wrap; steps land on cycles 3 mod 4.
        for (int cyc = 27; cyc <= 46; cyc++) begin
            tick(1'b0, 1'b1, 1'b1);
            chk($sformatf("run_pos c%0d", cyc), 32'(bus.pos), 32'(((cyc - 7) / 4) % 8));
            chk($sformatf("run_step c%0d", cyc), 32'(bus.step), 32'(cyc % 4 == 3));
        end

        // Counter-clockwise from reset wraps down to 7.
        tick(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (k == 3) chk("ccw pre-step pos", 32'({bus.pos, bus.step}), 32'({3'd0, 1'b0}));
            if (k == 4) chk("ccw wrap pos", 32'({bus.pos, bus.step}), 32'({3'd7, 1'b1}));
            if (k == 7) chk("ccw digit3 bot", 32'({bus.an, bus.sseg}), 32'({4'b0111, B}));
        end

        // Pause at tick_cnt=2 for 10 cycles.
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        for (int k = 3; k <= 12; k++) begin
            tick(1'b0, 1'b0, 1'b1);
            chk($sformatf("pause hold k%0d", k), 32'({bus.pos, bus.step}), 32'({3'd0, 1'b0}));
            if (k == 5) chk("pause scan an k5", 32'(bus.an), 32'(4'b1011));
            if (k == 9) chk("pause scan an k9", 32'(bus.an), 32'(4'b1110));
        end
        tick(1'b0, 1'b1, 1'b1);
        chk("resume +1", 32'({bus.pos, bus.step}), 32'({3'd0, 1'b0}));
        tick(1'b0, 1'b1, 1'b1);
        chk("resume +2 step", 32'({bus.pos, bus.step}), 32'({3'd1, 1'b1}));

        // Direction change mid-interval at pos=3.
        tick(1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 13; k++) tick(1'b0, 1'b1, 1'b1);
        chk("dir pos3", 32'(bus.pos), 32'd3);
        for (int k = 14; k <= 16; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (k == 15) chk("dir hold", 32'({bus.pos, bus.step}), 32'({3'd3, 1'b0}));
            if (k == 16) chk("dir reversed", 32'({bus.pos, bus.step}), 32'({3'd2, 1'b1}));
        end

        // Reset coincident with a step event at pos=5.
        tick(1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 23; k++) tick(1'b0, 1'b1, 1'b1);
        chk("pre-reset pos5", 32'({bus.pos, bus.step}), 32'({3'd5, 1'b0}));
        tick(1'b1, 1'b1, 1'b1);
        chk("reset over step", 32'({bus.an, bus.sseg, bus.pos, bus.step}),
            32'({4'b1111, K, 3'd0, 1'b0}));
        tick(1'b0, 1'b1, 1'b1);
        chk("post-reset", 32'({bus.pos, bus.step}), 32'({3'd0, 1'b0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
